// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits are served combinationally;
// misses issue a single-word read to the memory controller and fill the line on completion.
module icache #(
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned TAG_WIDTH   = 30 - INDEX_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rdy_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    output logic        if_hit_o,
    output logic [31:0] if_inst_o,
    input  logic        clr_i,
    output logic        mc_req_o,
    output logic [31:0] mc_addr_o,
    input  logic        mc_done_i,
    input  logic [31:0] mc_data_i
);

    localparam int unsigned Lines = 2 ** INDEX_WIDTH;

    typedef enum logic {StIdle, StWait} state_e;

    state_e                 state_q;
    logic                   mc_req_q;
    logic [31:0]            mc_addr_q;
    logic [Lines-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]   tag_q  [Lines];
    logic [31:0]            data_q [Lines];

    logic [INDEX_WIDTH-1:0] pc_idx;
    logic [TAG_WIDTH-1:0]   pc_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]   fill_tag;
    logic                   fill_en;
    logic                   unused_pc;

    assign pc_idx    = if_pc_i[INDEX_WIDTH+1:2];
    assign pc_tag    = if_pc_i[31:INDEX_WIDTH+2];
    assign unused_pc = ^if_pc_i[1:0];

    // The fill always targets the latched request address, not the current pc.
    assign fill_idx  = mc_addr_q[INDEX_WIDTH+1:2];
    assign fill_tag  = mc_addr_q[31:INDEX_WIDTH+2];
    assign fill_en   = (state_q == StWait) && rdy_i && mc_done_i && !rst_i;

    always_comb begin
        if_hit_o  = if_valid_i && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag) &&
                    (state_q == StIdle) && !rst_i;
        if_inst_o = if_hit_o ? data_q[pc_idx] : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mc_req_q  <= 1'b0;
            mc_addr_q <= 32'h0;
        end else if (rdy_i) begin
            unique case (state_q)
                StIdle: begin
                    if (if_valid_i && !if_hit_o && !clr_i) begin
                        state_q   <= StWait;
                        mc_req_q  <= 1'b1;
                        mc_addr_q <= {if_pc_i[31:2], 2'b00};
                    end
                end
                StWait: begin
                    // clr is deliberately ignored here: the controller cannot abort a word.
                    if (mc_done_i) begin
                        state_q  <= StIdle;
                        mc_req_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mc_data_i;
        end
    end

    assign mc_req_o  = mc_req_q;
    assign mc_addr_o = mc_addr_q;

endmodule
